// File: rtl/l1icache_fill_engine_if.sv
// Purpose : bundles the L1 I-cache miss port, lower-memory request/response and cache write port.
// Latency : none (wiring only).
// Backpressure: miss uses missReady_o; request uses l2ReqValid_o/l2ReqReady_i; response beats cannot be stalled.
// Ports   : master = the fill engine, slave = cache front end plus lower memory.
interface l1icache_fill_engine_if #(
  parameter int SIZE_PC          = 32,
  parameter int SIZE_INSTRUCTION = 64,
  parameter int BEATS            = 4
);
  logic                              miss_i;
  logic [SIZE_PC-1:0]                missAddr_i;
  logic                              missReady_o;
  logic                              flush_i;
  logic                              l2ReqValid_o;
  logic [SIZE_PC-1:0]                l2ReqAddr_o;
  logic                              l2ReqReady_i;
  logic                              l2RespValid_i;
  logic [SIZE_INSTRUCTION-1:0]       l2RespData_i;
  logic                              wrEnable_o;
  logic [SIZE_PC-1:0]                wrAddr_o;
  logic [BEATS*SIZE_INSTRUCTION-1:0] instBlock_o;
  logic                              busy_o;

  modport master (
    input  miss_i, missAddr_i, flush_i, l2ReqReady_i, l2RespValid_i, l2RespData_i,
    output missReady_o, l2ReqValid_o, l2ReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );

  modport slave (
    output miss_i, missAddr_i, flush_i, l2ReqReady_i, l2RespValid_i, l2RespData_i,
    input  missReady_o, l2ReqValid_o, l2ReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );
endinterface

// File: rtl/l1icache_fill_engine.sv
// Purpose : single-outstanding L1 I-cache refill: one block-aligned read, collect BEATS beats, one-cycle cache write.
// Latency : miss accepted at T -> request at T+1 -> (ready at T+1, beats T+2..T+5) -> write strobe at T+6, ready again T+7.
// Backpressure: request held stable until l2ReqReady_i; beats may have gaps; misses refused (missReady_o=0) while busy or flushing.
// Ports   : clk, reset (async active-low), bus (l1icache_fill_engine_if.master).
module l1icache_fill_engine #(
  parameter int SIZE_PC          = 32,
  parameter int SIZE_INSTRUCTION = 64,
  parameter int BEATS            = 4
) (
  input logic                   clk,
  input logic                   reset,
  l1icache_fill_engine_if.master bus
);

  localparam int BLOCK_BYTES = BEATS * SIZE_INSTRUCTION / 8;
  localparam int CNT_W       = $clog2(BEATS);
  localparam logic [SIZE_PC-1:0] ALIGN_MASK = ~(SIZE_PC'(BLOCK_BYTES - 1));
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RECV, FILL, DRAIN} state_t;

  state_t                            state;
  logic [CNT_W-1:0]                  beat_cnt;
  logic [SIZE_PC-1:0]                blk_addr;
  logic [BEATS*SIZE_INSTRUCTION-1:0] blk_data;
  logic [BEATS*SIZE_INSTRUCTION-1:0] blk_merged;
  logic                              last_beat;
  logic                              req_vld;
  logic                              wr_en;
  logic [SIZE_PC-1:0]                wr_addr;
  logic [BEATS*SIZE_INSTRUCTION-1:0] inst_blk;
  logic                              busy;

  // Block as it looks once the current beat is placed; lets the final beat go
  // straight into the write data without an extra assembly cycle.
  always_comb begin
    blk_merged = blk_data;
    blk_merged[beat_cnt*SIZE_INSTRUCTION +: SIZE_INSTRUCTION] = bus.l2RespData_i;
  end

  assign last_beat = bus.l2RespValid_i && (beat_cnt == LAST_CNT);

  assign bus.missReady_o  = (state == IDLE) && !bus.flush_i;
  assign bus.l2ReqValid_o = req_vld;
  assign bus.l2ReqAddr_o  = blk_addr;
  assign bus.wrEnable_o   = wr_en;
  assign bus.wrAddr_o     = wr_addr;
  assign bus.instBlock_o  = inst_blk;
  assign bus.busy_o       = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      blk_addr <= '0;
      blk_data <= '0;
      req_vld  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      inst_blk <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_i && !bus.flush_i) begin
            blk_addr <= bus.missAddr_i & ALIGN_MASK;
            req_vld  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (bus.l2ReqReady_i) begin
            // Once the handshake happens the memory will return beats, so a
            // simultaneous flush must still drain them.
            req_vld  <= 1'b0;
            beat_cnt <= '0;
            state    <= bus.flush_i ? DRAIN : RECV;
          end else if (bus.flush_i) begin
            req_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        RECV: begin
          if (bus.l2RespValid_i) begin
            blk_data <= blk_merged;
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (bus.flush_i) begin
            if (last_beat) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (last_beat) begin
            wr_en    <= 1'b1;
            wr_addr  <= blk_addr;
            inst_blk <= blk_merged;
            state    <= FILL;
          end
        end

        DRAIN: begin
          if (bus.l2RespValid_i) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (last_beat) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        FILL: begin
          // Flush is deliberately ignored here: the block is already complete.
          wr_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          req_vld <= 1'b0;
          wr_en   <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1icache_fill_engine.sv
// Purpose : self-checking bench for l1icache_fill_engine; directed scenarios plus randomized transactions.
// Latency : n/a (bench).
// Backpressure: bench drives request backpressure, beat gaps, flushes and async reset.
module tb_l1icache_fill_engine;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_count = 0;

  l1icache_fill_engine_if #(.SIZE_PC(32), .SIZE_INSTRUCTION(64), .BEATS(4)) bus ();

  l1icache_fill_engine #(.SIZE_PC(32), .SIZE_INSTRUCTION(64), .BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the write strobe is seen high.
  always @(negedge clk) begin
    if (bus.wrEnable_o === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Modes: 0 normal, 1 flush in REQ before ready, 2 flush with beat fl_at,
  // 3 flush during FILL, 4 flush together with request handshake,
  // 5 second miss (addr2) held during RECV, 6 async reset before beat fl_at,
  // 7 flush on an empty cycle just before beat fl_at.
  task automatic run_txn(input logic [31:0] addr, input int delay, input int gap,
                         input int mode, input int fl_at, input bit fixed,
                         input logic [31:0] addr2);
    logic [31:0]  al;
    logic [63:0]  beat [4];
    logic [255:0] exp_blk;
    int           wr0;
    int           g;
    bit           flushed;

    al      = addr & 32'hFFFF_FFE0;
    wr0     = wr_count;
    flushed = (mode == 2) || (mode == 4) || (mode == 7);
    exp_blk = '0;
    for (int i = 0; i < 4; i++) begin
      beat[i] = fixed ? (64'hA0 + 64'(i)) : {$urandom, $urandom};
      exp_blk[i*64 +: 64] = beat[i];
    end

    bus.miss_i     = 1'b1;
    bus.missAddr_i = addr;
    #1 chk1("miss_ready_idle", bus.missReady_o, 1'b1);
    cyc();
    bus.miss_i = 1'b0;
    #1;
    chk1 ("req_valid", bus.l2ReqValid_o, 1'b1);
    chk32("req_addr",  bus.l2ReqAddr_o,  al);
    chk1 ("busy_req",  bus.busy_o,       1'b1);

    for (int d = 0; d < delay; d++) begin
      bus.l2ReqReady_i  = 1'b0;
      bus.l2RespValid_i = 1'($urandom_range(0, 1));
      if (mode == 1 && d == fl_at) begin
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i       = 1'b0;
        bus.l2RespValid_i = 1'b0;
        #1;
        chk1 ("flush_req_valid", bus.l2ReqValid_o, 1'b0);
        chk1 ("flush_req_busy",  bus.busy_o,       1'b0);
        chk1 ("flush_req_ready", bus.missReady_o,  1'b1);
        chk32("flush_req_nowr",  wr_count,         wr0);
        return;
      end
      cyc();
      bus.l2RespValid_i = 1'b0;
      #1;
      chk1 ("req_hold_valid", bus.l2ReqValid_o, 1'b1);
      chk32("req_hold_addr",  bus.l2ReqAddr_o,  al);
    end

    bus.l2ReqReady_i = 1'b1;
    bus.flush_i      = (mode == 4);
    cyc();
    bus.l2ReqReady_i = 1'b0;
    bus.flush_i      = 1'b0;
    #1 chk1("req_drop", bus.l2ReqValid_o, 1'b0);

    if (mode == 5) begin
      bus.miss_i     = 1'b1;
      bus.missAddr_i = addr2;
    end

    for (int b = 0; b < 4; b++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      if (mode == 7 && b == fl_at) begin
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        #1 chk1("flush_gap_busy", bus.busy_o, 1'b1);
      end
      for (int k = 0; k < g; k++) begin
        cyc();
        #1 chk1("gap_nowr", bus.wrEnable_o, 1'b0);
        if (mode == 5) chk1("busy_reject_gap", bus.missReady_o, 1'b0);
      end
      if (mode == 6 && b == fl_at) begin
        #2 reset = 1'b0;
        #1;
        chk1 ("rst_req_valid", bus.l2ReqValid_o, 1'b0);
        chk32("rst_req_addr",  bus.l2ReqAddr_o,  32'h0);
        chk1 ("rst_wr_en",     bus.wrEnable_o,   1'b0);
        chk32("rst_wr_addr",   bus.wrAddr_o,     32'h0);
        chk256("rst_block",    bus.instBlock_o,  256'h0);
        chk1 ("rst_busy",      bus.busy_o,       1'b0);
        cyc();
        reset = 1'b1;
        return;
      end
      bus.l2RespValid_i = 1'b1;
      bus.l2RespData_i  = beat[b];
      bus.flush_i       = (mode == 2 && b == fl_at);
      cyc();
      bus.l2RespValid_i = 1'b0;
      bus.flush_i       = 1'b0;
      #1;
      if (b < 3) begin
        chk1("recv_nowr", bus.wrEnable_o, 1'b0);
        if (mode == 5) begin
          chk1("busy_reject",   bus.missReady_o,  1'b0);
          chk1("no_second_req", bus.l2ReqValid_o, 1'b0);
        end
      end
    end

    if (flushed) begin
      chk1 ("drain_nowr",  bus.wrEnable_o,  1'b0);
      chk1 ("drain_busy",  bus.busy_o,      1'b0);
      chk1 ("drain_ready", bus.missReady_o, 1'b1);
      chk32("drain_count", wr_count,        wr0);
    end else begin
      if (mode == 3) bus.flush_i = 1'b1;
      #1;
      chk1  ("fill_wr_en",  bus.wrEnable_o,   1'b1);
      chk32 ("fill_addr",   bus.wrAddr_o,     al);
      chk256("fill_block",  bus.instBlock_o,  exp_blk);
      chk1  ("fill_noready", bus.missReady_o, 1'b0);
      cyc();
      bus.flush_i = 1'b0;
      #1;
      chk1 ("post_fill_wr_en", bus.wrEnable_o,  1'b0);
      chk1 ("post_fill_busy",  bus.busy_o,      1'b0);
      chk1 ("post_fill_ready", bus.missReady_o, 1'b1);
      chk32("one_write",       wr_count,        wr0 + 1);
    end
  endtask

  initial begin
    int mode_tab [7];
    int m;
    int dly;
    int fa;

    mode_tab = '{0, 0, 1, 2, 3, 4, 7};
    reset             = 1'b0;
    bus.miss_i        = 1'b0;
    bus.missAddr_i    = '0;
    bus.flush_i       = 1'b0;
    bus.l2ReqReady_i  = 1'b0;
    bus.l2RespValid_i = 1'b0;
    bus.l2RespData_i  = '0;

    #12;
    chk1  ("reset_req_valid", bus.l2ReqValid_o, 1'b0);
    chk32 ("reset_req_addr",  bus.l2ReqAddr_o,  32'h0);
    chk1  ("reset_wr_en",     bus.wrEnable_o,   1'b0);
    chk32 ("reset_wr_addr",   bus.wrAddr_o,     32'h0);
    chk256("reset_block",     bus.instBlock_o,  256'h0);
    chk1  ("reset_busy",      bus.busy_o,       1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();

    // Miss offered during flush in IDLE is refused.
    bus.flush_i    = 1'b1;
    bus.miss_i     = 1'b1;
    bus.missAddr_i = 32'h0000_5000;
    #1 chk1("flush_idle_noready", bus.missReady_o, 1'b0);
    cyc();
    bus.flush_i = 1'b0;
    bus.miss_i  = 1'b0;
    #1;
    chk1("flush_idle_busy",  bus.busy_o,       1'b0);
    chk1("flush_idle_noreq", bus.l2ReqValid_o, 1'b0);

    // A stray beat in IDLE must not disturb the next block.
    bus.l2RespValid_i = 1'b1;
    bus.l2RespData_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc();
    bus.l2RespValid_i = 1'b0;

    run_txn(32'h0000_1234, 0, 0, 0, 0, 1'b1, 32'h0);          // basic fill
    run_txn(32'h0000_4568, 3, 1, 0, 0, 1'b0, 32'h0);          // backpressure + gaps
    run_txn(32'h0000_3010, 0, 0, 5, 0, 1'b0, 32'h0000_2000);  // busy rejection
    run_txn(32'h0000_2000, 0, 0, 0, 0, 1'b0, 32'h0);          // held miss now accepted
    run_txn(32'h0000_6004, 2, 0, 1, 1, 1'b0, 32'h0);          // flush in REQ
    run_txn(32'h0000_7000, 0, 1, 7, 1, 1'b0, 32'h0);          // flush in RECV after 1 beat
    run_txn(32'h0000_8018, 0, 0, 2, 3, 1'b0, 32'h0);          // flush with final beat
    run_txn(32'h0000_9000, 1, 0, 3, 0, 1'b0, 32'h0);          // flush during FILL
    run_txn(32'h0000_A01F, 0, 0, 4, 0, 1'b0, 32'h0);          // flush at request handshake
    run_txn(32'h0000_B000, 0, 0, 6, 2, 1'b0, 32'h0);          // async reset mid-RECV
    run_txn(32'h0000_C0E8, 0, 0, 0, 0, 1'b0, 32'h0);          // clean fill after reset

    for (int t = 0; t < 24; t++) begin
      m   = mode_tab[$urandom_range(0, 6)];
      dly = int'($urandom_range(0, 3));
      if (m == 1 && dly == 0) dly = 1;
      fa  = (m == 1) ? int'($urandom_range(0, dly - 1)) : int'($urandom_range(0, 3));
      run_txn($urandom, dly, -1, m, fa, 1'b0, 32'h0);
    end

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l1icache_fill_engine.md
Name: l1icache_fill_engine

Overview:
- Miss-handling and refill engine on the memory side of the L1 instruction cache.
- Accepts the cache's miss request (miss / miss address) and issues one block-aligned read to the lower-level memory.
- Collects the returned beats into a 4-instruction block and drives the cache write port (write enable, write address, instruction block) for one cycle.
- Single outstanding miss; supports flush with drain of in-flight beats.

Parameters:
SIZE_PC, 32, address width in bits
SIZE_INSTRUCTION, 64, instruction width (opcode half + operand half); one instruction = 8 bytes
BEATS, 4, response beats per block; one instruction per beat; block = 32 bytes

Ports:
clk  input  1  clock
reset  input  1  reset; one clock; reset is asynchronous and active-low
miss_i  input  1  miss request from L1 I-cache
missAddr_i  input  SIZE_PC  miss address; any byte within the block
missReady_o  output  1  miss accepted this cycle when miss_i=1
flush_i  input  1  front-end flush; abandon current miss
l2ReqValid_o  output  1  read request valid to lower memory
l2ReqAddr_o  output  SIZE_PC  block-aligned request address
l2ReqReady_i  input  1  lower memory accepts request
l2RespValid_i  input  1  response beat valid
l2RespData_i  input  SIZE_INSTRUCTION  response beat (one instruction)
wrEnable_o  output  1  cache write strobe
wrAddr_o  output  SIZE_PC  block-aligned write address
instBlock_o  output  4*SIZE_INSTRUCTION  assembled block; instruction at offset 0 in bits [SIZE_INSTRUCTION-1:0]
busy_o  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; beat counter=0; block address and data registers=0.
  - All outputs 0 except missReady_o, which follows its combinational rule (=1 while reset is released and flush_i=0).
- Block alignment: addr & ~(32-1), i.e. low 5 bits cleared. Applies to l2ReqAddr_o and wrAddr_o.
- missReady_o = (state==IDLE) && !flush_i (combinational).
- States: IDLE, REQ, RECV, FILL, DRAIN.
- IDLE:
  - miss_i && missReady_o -> latch aligned address, go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - l2ReqValid_o=1; l2ReqAddr_o stable until handshake.
  - l2ReqReady_i=1 -> RECV, beat counter=0.
  - flush_i=1 and l2ReqReady_i=0 -> IDLE, no request issued.
  - flush_i=1 and l2ReqReady_i=1 in the same cycle -> request counts as issued; go to DRAIN.
- RECV:
  - Each cycle with l2RespValid_i: store beat in slot = counter, then increment counter.
  - Beat BEATS-1 accepted -> FILL.
  - Gaps (l2RespValid_i=0) allowed indefinitely.
  - flush_i=1 -> DRAIN, counter continues; a beat arriving that same cycle is counted.
- DRAIN:
  - Absorb and count remaining beats; no write.
  - Last beat counted -> IDLE.
  - If the beat completing the block arrives in the flush cycle itself, go straight to IDLE.
- FILL:
  - Exactly one cycle: wrEnable_o=1, wrAddr_o=latched address, instBlock_o=assembled data.
  - Then IDLE.
  - flush_i has no effect in FILL; the write still occurs.
- wrEnable_o is 0 in all states except FILL. wrAddr_o/instBlock_o hold their last values otherwise.
- miss_i while not IDLE: not accepted, no side effect. The requester holds miss_i and the address until missReady_o. Same-block duplicates therefore re-hit after the fill.
- l2RespValid_i in IDLE/REQ/FILL: ignored; the beat counter is unchanged.
- Minimum latency:
  - Miss accepted at cycle T; l2ReqValid_o at T+1.
  - With l2ReqReady_i at T+1 and beats at T+2..T+5, wrEnable_o=1 at T+6.
  - missReady_o=1 again at T+7.
- Reset mid-operation: immediate return to the reset state. Any later beats from the abandoned request are outside this block's responsibility; memory is reset too.

Test Plan:
- Basic fill: miss_i=1, missAddr_i=0x0000_1234, ready immediate, beats 0xA0..0xA3 back-to-back -> l2ReqAddr_o=0x0000_1220; single wrEnable_o at T+6 with wrAddr_o=0x0000_1220 and instBlock_o={0xA3,0xA2,0xA1,0xA0}.
- Backpressure and gaps: l2ReqReady_i low for 3 cycles, then beats with 1-cycle gaps -> l2ReqValid_o and l2ReqAddr_o held stable for 4 cycles; fill occurs only after the 4th beat; exactly one write pulse.
- Busy rejection: second miss to 0x2000 issued during RECV -> missReady_o=0, no second request; after the first FILL, 0x2000 is accepted in IDLE and a second request is issued with l2ReqAddr_o=0x2000.
- Flush in REQ before ready -> l2ReqValid_o drops next cycle, no write, busy_o=0. Flush in RECV after 1 beat -> 3 more beats absorbed, no wrEnable_o, missReady_o=1 after the last beat.
- Flush coincident with final beat in RECV -> straight to IDLE, no write. Flush during FILL -> write still issued.
- Async reset asserted mid-RECV -> all outputs 0 immediately; after release, a new miss completes normally with correct data (no stale beats).
